prefetch_stream_table: RTL and testbench

PREFETCH_STREAM_TABLE -- requirements
Module: prefetch_stream_table

---
 rtl/prefetch_pkg.sv | 17 +
 rtl/prefetch_stream_entry.sv | 139 +++++++++++++
 rtl/prefetch_stream_table.sv | 143 ++++++++++++++
 tb/tb_prefetch_stream_table.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and default sizing for the stream prefetch table.
// The state encoding is visible on the stream_state port, so its values are fixed.
package prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_CLEANUP = 2'd3
    } stream_state_e;

    localparam int DEF_ADDR_BITS   = 16;
    localparam int DEF_TID_WIDTH   = 8;
    localparam int DEF_NUM_STREAMS = 4;
    localparam int DEF_CNT_WIDTH   = 4;

endpackage

// File: rtl/prefetch_stream_entry.sv
// One stream-table entry: stride training, sequence tracking, and the
// outstanding-prefetch / promised-delivery counters of a single stream.
module prefetch_stream_entry
    import prefetch_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int TID_WIDTH = DEF_TID_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 obs_valid,
    input  logic [ADDR_BITS-1:0] obs_addr,
    input  logic [TID_WIDTH-1:0] obs_id,
    input  logic                 alloc,
    input  logic                 pending,
    input  logic                 issue,
    input  logic                 done,
    input  logic                 dlv,
    input  logic [ADDR_BITS-1:0] bar,
    input  logic [ADDR_BITS-1:0] limit,
    input  logic [CNT_WIDTH-1:0] out_limit,
    output stream_state_e        state,
    output logic                 match,
    output logic                 eligible,
    output logic [ADDR_BITS-1:0] next_pf,
    output logic [TID_WIDTH-1:0] id,
    output logic                 err_event
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    stream_state_e        state_reg;
    logic [TID_WIDTH-1:0] id_reg;
    logic [ADDR_BITS-1:0] last_addr_reg;
    logic [ADDR_BITS-1:0] stride_reg;
    logic [ADDR_BITS-1:0] next_pf_reg;
    logic [CNT_WIDTH-1:0] outstanding_reg, outstanding_next;
    logic [CNT_WIDTH-1:0] promise_reg, promise_next;

    logic [ADDR_BITS-1:0] expected_addr;
    logic [ADDR_BITS-1:0] train_stride;
    logic hit, seq_hit, seq_miss, id_break;
    logic in_range, range_exit, to_cleanup, drained;
    logic out_err, prom_err;

    assign expected_addr = last_addr_reg + stride_reg;
    assign train_stride  = obs_addr - last_addr_reg;

    assign match    = (state_reg != ST_IDLE) && (id_reg == obs_id);
    assign hit      = obs_valid && match;
    assign seq_hit  = hit && (state_reg == ST_ACTIVE) && (obs_addr == expected_addr);
    assign seq_miss = hit && (state_reg == ST_ACTIVE) && (obs_addr != expected_addr);
    // Another master walking onto this stream's next address breaks the stream.
    assign id_break = obs_valid && (state_reg == ST_ACTIVE) && (id_reg != obs_id)
                      && (obs_addr == expected_addr);

    assign in_range   = (next_pf_reg >= bar) && (next_pf_reg < limit);
    // A request already presented downstream is allowed to complete first.
    assign range_exit = (state_reg == ST_ACTIVE) && !in_range && !pending;
    assign to_cleanup = seq_miss || id_break || range_exit;
    assign eligible   = (state_reg == ST_ACTIVE) && in_range && !to_cleanup
                        && (outstanding_reg < out_limit);
    assign drained    = (outstanding_reg == '0) && (promise_reg == '0) && !pending;

    always_comb begin
        outstanding_next = outstanding_reg;
        promise_next     = promise_reg;
        out_err          = 1'b0;
        prom_err         = 1'b0;
        if (issue && !done) begin
            if (outstanding_reg == CNT_MAX) out_err = 1'b1;
            else outstanding_next = outstanding_reg + CNT_ONE;
        end else if (done && !issue) begin
            if (outstanding_reg == '0) out_err = 1'b1;
            else outstanding_next = outstanding_reg - CNT_ONE;
        end
        if (seq_hit && !dlv) begin
            if (promise_reg == CNT_MAX) prom_err = 1'b1;
            else promise_next = promise_reg + CNT_ONE;
        end else if (dlv && !seq_hit) begin
            if (promise_reg == '0) prom_err = 1'b1;
            else promise_next = promise_reg - CNT_ONE;
        end
    end

    assign err_event = out_err || prom_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            id_reg          <= '0;
            last_addr_reg   <= '0;
            stride_reg      <= '0;
            next_pf_reg     <= '0;
            outstanding_reg <= '0;
            promise_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            promise_reg     <= promise_next;
            if (issue) next_pf_reg <= next_pf_reg + stride_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (alloc) begin
                        state_reg     <= ST_TRAIN;
                        id_reg        <= obs_id;
                        last_addr_reg <= obs_addr;
                        stride_reg    <= '0;
                        next_pf_reg   <= '0;
                    end
                end
                ST_TRAIN: begin
                    if (hit) begin
                        last_addr_reg <= obs_addr;
                        stride_reg    <= train_stride;
                        if (train_stride != '0) begin
                            state_reg   <= ST_ACTIVE;
                            next_pf_reg <= obs_addr + train_stride;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (seq_hit) last_addr_reg <= obs_addr;
                    if (to_cleanup) state_reg <= ST_CLEANUP;
                end
                ST_CLEANUP: begin
                    if (drained) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign state   = state_reg;
    assign next_pf = next_pf_reg;
    assign id      = id_reg;

endmodule

// File: rtl/prefetch_stream_table.sv
// Stream prefetch table: allocates entries from observed demand reads and
// round-robins prefetch requests from the ACTIVE entries onto one output port.
module prefetch_stream_table
    import prefetch_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int TID_WIDTH   = DEF_TID_WIDTH,
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           obs_valid,
    input  logic [ADDR_BITS-1:0]           obs_addr,
    input  logic [TID_WIDTH-1:0]           obs_id,
    output logic                           pf_valid,
    input  logic                           pf_ready,
    output logic [ADDR_BITS-1:0]           pf_addr,
    output logic [TID_WIDTH-1:0]           pf_id,
    output logic [$clog2(NUM_STREAMS)-1:0] pf_stream,
    input  logic                           done_valid,
    input  logic [$clog2(NUM_STREAMS)-1:0] done_stream,
    input  logic                           dlv_valid,
    input  logic [$clog2(NUM_STREAMS)-1:0] dlv_stream,
    input  logic [ADDR_BITS-1:0]           bar,
    input  logic [ADDR_BITS-1:0]           limit,
    input  logic [CNT_WIDTH-1:0]           out_limit,
    output logic [2*NUM_STREAMS-1:0]       stream_state,
    output logic                           err
);

    localparam int SW = $clog2(NUM_STREAMS);

    logic [NUM_STREAMS-1:0] match_vec, idle_vec, alloc_vec, elig_vec;
    logic [NUM_STREAMS-1:0] pending_vec, issue_vec, done_vec, dlv_vec, err_vec;
    logic [ADDR_BITS-1:0]   next_pf_arr [NUM_STREAMS];
    logic [TID_WIDTH-1:0]   id_arr [NUM_STREAMS];
    stream_state_e          state_arr [NUM_STREAMS];

    logic                 pf_valid_reg;
    logic [ADDR_BITS-1:0] pf_addr_reg;
    logic [TID_WIDTH-1:0] pf_id_reg;
    logic [SW-1:0]        pf_stream_reg;
    logic [SW-1:0]        ptr_reg;
    logic                 err_reg;

    logic          any_match, alloc_found, grant_found;
    logic [SW-1:0] grant_idx, cand;

    generate
        for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_entry
            assign pending_vec[gi] = pf_valid_reg && (pf_stream_reg == SW'(gi));
            assign issue_vec[gi]   = pending_vec[gi] && pf_ready;
            assign done_vec[gi]    = done_valid && (done_stream == SW'(gi));
            assign dlv_vec[gi]     = dlv_valid && (dlv_stream == SW'(gi));
            assign idle_vec[gi]    = (state_arr[gi] == ST_IDLE);
            assign stream_state[2*gi +: 2] = state_arr[gi];

            prefetch_stream_entry #(
                .ADDR_BITS(ADDR_BITS),
                .TID_WIDTH(TID_WIDTH),
                .CNT_WIDTH(CNT_WIDTH)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .obs_valid (obs_valid),
                .obs_addr  (obs_addr),
                .obs_id    (obs_id),
                .alloc     (alloc_vec[gi]),
                .pending   (pending_vec[gi]),
                .issue     (issue_vec[gi]),
                .done      (done_vec[gi]),
                .dlv       (dlv_vec[gi]),
                .bar       (bar),
                .limit     (limit),
                .out_limit (out_limit),
                .state     (state_arr[gi]),
                .match     (match_vec[gi]),
                .eligible  (elig_vec[gi]),
                .next_pf   (next_pf_arr[gi]),
                .id        (id_arr[gi]),
                .err_event (err_vec[gi])
            );
        end
    endgenerate

    // Unmatched observations claim the lowest-index IDLE entry, or are dropped.
    always_comb begin
        any_match   = |match_vec;
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (!alloc_found && idle_vec[i]) begin
                alloc_vec[i] = obs_valid && !any_match;
                alloc_found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            cand = ptr_reg + SW'(k);
            if (!grant_found && elig_vec[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Arbitration only runs with the output slot empty, so every grant sees
    // the entry's counters and next_pf already updated by the previous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid_reg  <= 1'b0;
            pf_addr_reg   <= '0;
            pf_id_reg     <= '0;
            pf_stream_reg <= '0;
            ptr_reg       <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= err_reg || (|err_vec);
            if (pf_valid_reg && pf_ready) begin
                pf_valid_reg <= 1'b0;
            end else if (!pf_valid_reg && grant_found) begin
                pf_valid_reg  <= 1'b1;
                pf_addr_reg   <= next_pf_arr[grant_idx];
                pf_id_reg     <= id_arr[grant_idx];
                pf_stream_reg <= grant_idx;
                ptr_reg       <= grant_idx + SW'(1);
            end
        end
    end

    assign pf_valid  = pf_valid_reg;
    assign pf_addr   = pf_addr_reg;
    assign pf_id     = pf_id_reg;
    assign pf_stream = pf_stream_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_prefetch_stream_table.sv
// Scoreboard bench: stimulus pushes expected prefetches, a negedge monitor pops
// and compares each handshake; state/err checks are made 1 time unit after edges.
module tb_prefetch_stream_table;
    import prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        obs_valid = 1'b0;
    logic [15:0] obs_addr = '0;
    logic [7:0]  obs_id = '0;
    logic        pf_valid;
    logic        pf_ready = 1'b0;
    logic [15:0] pf_addr;
    logic [7:0]  pf_id;
    logic [1:0]  pf_stream;
    logic        done_valid = 1'b0;
    logic [1:0]  done_stream = '0;
    logic        dlv_valid = 1'b0;
    logic [1:0]  dlv_stream = '0;
    logic [15:0] bar = '0;
    logic [15:0] limit = 16'hFFFF;
    logic [3:0]  out_limit = 4'd3;
    logic [7:0]  stream_state;
    logic        err;

    always #5 clk = ~clk;

    prefetch_stream_table dut (
        .clk(clk), .rst(rst),
        .obs_valid(obs_valid), .obs_addr(obs_addr), .obs_id(obs_id),
        .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr),
        .pf_id(pf_id), .pf_stream(pf_stream),
        .done_valid(done_valid), .done_stream(done_stream),
        .dlv_valid(dlv_valid), .dlv_stream(dlv_stream),
        .bar(bar), .limit(limit), .out_limit(out_limit),
        .stream_state(stream_state), .err(err)
    );

    typedef struct packed {
        logic [1:0]  stream;
        logic [15:0] addr;
        logic [7:0]  id;
    } pf_t;

    pf_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_pf(input logic [1:0] s, input logic [15:0] a, input logic [7:0] i);
        exp_q.push_back({s, a, i});
    endtask

    // Monitor: compares every handshake against the scoreboard and checks hold.
    initial begin
        pf_t e;
        pf_t held;
        logic hold_chk;
        hold_chk = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    check("pf_hold_valid", {31'd0, pf_valid}, 32'd1);
                    check("pf_hold_addr", {16'd0, pf_addr}, {16'd0, held.addr});
                    check("pf_hold_stream", {30'd0, pf_stream}, {30'd0, held.stream});
                end
                if (pf_valid && pf_ready) begin
                    $display("[TB] pf stream=%0d addr=0x%04h id=0x%02h", pf_stream, pf_addr, pf_id);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pf_unexpected: got stream %0d addr 0x%04h, expected no prefetch",
                                 pf_stream, pf_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("pf_stream", {30'd0, pf_stream}, {30'd0, e.stream});
                        check("pf_addr", {16'd0, pf_addr}, {16'd0, e.addr});
                        check("pf_id", {24'd0, pf_id}, {24'd0, e.id});
                    end
                end
                hold_chk = pf_valid && !pf_ready;
                held = {pf_stream, pf_addr, pf_id};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_obs(input logic [7:0] i, input logic [15:0] a);
        obs_valid = 1'b1;
        obs_id = i;
        obs_addr = a;
        tick();
        obs_valid = 1'b0;
    endtask

    task automatic send_done();
        done_valid = 1'b1;
        done_stream = 2'd0;
        tick();
        done_valid = 1'b0;
    endtask

    task automatic send_dlv();
        dlv_valid = 1'b1;
        dlv_stream = 2'd0;
        tick();
        dlv_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic in_win(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a < hi);
    endfunction

    initial begin
        logic [7:0]  idv;
        logic [15:0] a0, a1, s, nxt, last;
        int          ol, n, p, m, cnt;
        logic        final_active;

        // Reset state
        do_reset();
        check("rst_pf_valid", {31'd0, pf_valid}, 0);
        check("rst_state", {24'd0, stream_state}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_pf_addr", {16'd0, pf_addr}, 0);

        // Basic stream, out_limit 3, stall at limit
        bar = 16'h0000; limit = 16'hFFFF; out_limit = 4'd3; pf_ready = 1'b1;
        push_pf(2'd0, 16'h0EF5, 8'd5);
        push_pf(2'd0, 16'h0EF8, 8'd5);
        push_pf(2'd0, 16'h0EFB, 8'd5);
        send_obs(8'd5, 16'h0EEF);
        check("train_after_obs", {24'd0, stream_state}, 32'h01);
        send_obs(8'd5, 16'h0EF2);
        check("active_after_obs", {24'd0, stream_state}, 32'h02);
        tick();
        check("first_pf_latency", {31'd0, pf_valid}, 1);
        wait_drain("basic_drain", 100);
        repeat (10) tick();
        check("stall_pf_valid", {31'd0, pf_valid}, 0);
        check("stall_state", {24'd0, stream_state}, 32'h02);

        // ID break: other master hits entry0's next address
        send_obs(8'd6, 16'h0EF5);
        check("id_break_state", {24'd0, stream_state}, 32'h07);
        repeat (3) send_done();
        check("cleanup_after_done", {24'd0, stream_state}, 32'h07);
        tick();
        check("idle_after_drain", {24'd0, stream_state}, 32'h04);
        check("no_err_basic", {31'd0, err}, 0);

        // Two streams, toggling ready: strict alternation
        do_reset();
        out_limit = 4'd4; pf_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_pf(2'd0, 16'h1008 + 16'(4 * k), 8'd1);
            push_pf(2'd1, 16'h2010 + 16'(8 * k), 8'd2);
        end
        send_obs(8'd1, 16'h1000);
        send_obs(8'd2, 16'h2000);
        send_obs(8'd1, 16'h1004);
        send_obs(8'd2, 16'h2008);
        check("two_active", {24'd0, stream_state}, 32'h0A);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            pf_ready = ~pf_ready;
            tick();
            cnt++;
        end
        check("rr_drain", exp_q.size(), 0);
        pf_ready = 1'b1;
        repeat (6) tick();

        // Limit reached after a single prefetch
        do_reset();
        limit = 16'h0EF8; out_limit = 4'd3; pf_ready = 1'b1;
        push_pf(2'd0, 16'h0EF5, 8'd5);
        send_obs(8'd5, 16'h0EEF);
        send_obs(8'd5, 16'h0EF2);
        wait_drain("limit_drain", 50);
        repeat (4) tick();
        check("limit_cleanup", {24'd0, stream_state}, 32'h03);
        send_done();
        check("limit_cleanup_hold", {24'd0, stream_state}, 32'h03);
        tick();
        check("limit_idle", {24'd0, stream_state}, 32'h00);

        // Underflow sets sticky err; reset mid-burst clears everything
        do_reset();
        limit = 16'hFFFF;
        send_done();
        check("err_set", {31'd0, err}, 1);
        repeat (4) tick();
        check("err_sticky", {31'd0, err}, 1);
        out_limit = 4'd8; pf_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push_pf(2'd0, 16'h0EF2 + 16'(3 * k), 8'd5);
        send_obs(8'd5, 16'h0EEF);
        send_obs(8'd5, 16'h0EF2);
        cnt = 0;
        while (exp_q.size() > 6 && cnt < 50) begin
            tick();
            cnt++;
        end
        check("burst_started", {31'd0, (exp_q.size() <= 6)}, 1);
        do_reset();
        check("midrst_pf_valid", {31'd0, pf_valid}, 0);
        check("midrst_state", {24'd0, stream_state}, 0);
        check("midrst_err", {31'd0, err}, 0);
        check("midrst_pf_addr", {16'd0, pf_addr}, 0);
        check("midrst_pf_id", {24'd0, pf_id}, 0);
        repeat (3) tick();

        // Randomized single streams with promises and random backpressure
        for (int it = 0; it < 20; it++) begin
            do_reset();
            idv = 8'($urandom_range(0, 255));
            a0 = 16'($urandom_range(16'h0100, 16'hD000));
            s = 16'($urandom_range(1, 7));
            a1 = a0 + s;
            ol = $urandom_range(1, 5);
            m = $urandom_range(1, 8);
            p = $urandom_range(0, 3);
            bar = a0 - 16'($urandom_range(0, 16));
            limit = a1 + 16'(m) * s + 16'd1 + 16'($urandom_range(0, 6)) % s;
            out_limit = 4'(ol);
            pf_ready = 1'b0;
            // Reference: issue addresses a1+s, a1+2s, ... while in window and under the cap
            nxt = a1 + s;
            n = 0;
            while (n < ol && in_win(nxt, bar, limit)) begin
                push_pf(2'd0, nxt, idv);
                n++;
                nxt = nxt + s;
            end
            final_active = in_win(nxt, bar, limit);
            send_obs(idv, a0);
            check("rnd_train", {24'd0, stream_state}, 32'h01);
            send_obs(idv, a1);
            last = a1;
            for (int j = 0; j < p; j++) begin
                last = last + s;
                send_obs(idv, last);
            end
            cnt = 0;
            while (exp_q.size() != 0 && cnt < 400) begin
                pf_ready = 1'($urandom_range(0, 1));
                tick();
                cnt++;
            end
            pf_ready = 1'b1;
            repeat (6) tick();
            check("rnd_drain", exp_q.size(), 0);
            check("rnd_end_state", {24'd0, stream_state}, final_active ? 32'h02 : 32'h03);
            if (final_active) begin
                send_obs(idv, last + s + 16'd1);
                check("rnd_mismatch_cleanup", {24'd0, stream_state}, 32'h03);
            end
            for (int j = 0; j < n; j++) send_done();
            for (int j = 0; j < p; j++) send_dlv();
            check("rnd_cleanup_hold", {24'd0, stream_state}, 32'h03);
            tick();
            check("rnd_idle", {24'd0, stream_state}, 32'h00);
            check("rnd_no_err", {31'd0, err}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
